tick_pwm_gen: RTL and testbench

//  Sits directly downstream of the divide-by-3 clock-enable FSM and consumes its
//  one-in-three tick. Generates a PWM waveform whose period and high time are

---
 rtl/tick_pwm_pkg.sv | 14 +
 rtl/tick_pwm_shadow.sv | 63 ++++++
 rtl/tick_pwm_gen.sv | 129 ++++++++++++
 tb/tb_tick_pwm_gen.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/tick_pwm_pkg.sv
// Shared types and default constants for the tick-driven PWM generator.
package tick_pwm_pkg;

  localparam int unsigned CNT_W_DEF      = 8;
  localparam int unsigned PERIOD_RST_DEF = 3;
  localparam int unsigned DUTY_RST_DEF   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/tick_pwm_shadow.sv
// Config shadow registers: accepts period/duty over valid/ready, holds them
// as pending, and copies them into the active registers on an apply request.
module tick_pwm_shadow
  import tick_pwm_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned PERIOD_RST = PERIOD_RST_DEF,
  parameter int unsigned DUTY_RST   = DUTY_RST_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  input  logic             apply_req,
  output logic [CNT_W-1:0] period_act,
  output logic [CNT_W-1:0] duty_act,
  output logic [CNT_W-1:0] period_nxt,
  output logic [CNT_W-1:0] duty_nxt
);

  logic             r_pending;
  logic [CNT_W-1:0] r_shadow_period;
  logic [CNT_W-1:0] r_shadow_duty;
  logic [CNT_W-1:0] r_period_act;
  logic [CNT_W-1:0] r_duty_act;
  logic             w_accept;
  logic             w_apply;

  // Accept and apply are mutually exclusive: accept needs pending low, apply needs it high.
  assign w_accept = cfg_valid && !r_pending;
  assign w_apply  = apply_req && r_pending;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending       <= 1'b0;
      r_shadow_period <= '0;
      r_shadow_duty   <= '0;
      r_period_act    <= CNT_W'(PERIOD_RST);
      r_duty_act      <= CNT_W'(DUTY_RST);
    end else begin
      if (w_accept) begin
        r_shadow_period <= cfg_period;
        r_shadow_duty   <= cfg_duty;
        r_pending       <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
      if (w_apply) begin
        r_period_act <= r_shadow_period;
        r_duty_act   <= r_shadow_duty;
      end
    end
  end

  assign cfg_ready  = !r_pending;
  assign period_act = r_period_act;
  assign duty_act   = r_duty_act;
  assign period_nxt = w_apply ? r_shadow_period : r_period_act;
  assign duty_nxt   = w_apply ? r_shadow_duty   : r_duty_act;

endmodule

// File: rtl/tick_pwm_gen.sv
// Tick-counted PWM generator: IDLE/RUN/STOP control, period counter and
// registered outputs; new config takes effect only at period boundaries.
module tick_pwm_gen
  import tick_pwm_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned PERIOD_RST = PERIOD_RST_DEF,
  parameter int unsigned DUTY_RST   = DUTY_RST_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             pwm_out,
  output logic             period_start,
  output logic             busy
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pwm;
  logic             r_start;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_start_next;
  logic             w_pwm_next;
  logic [CNT_W-1:0] w_period_act;
  logic [CNT_W-1:0] w_duty_act;
  logic [CNT_W-1:0] w_period_nxt;
  logic [CNT_W-1:0] w_duty_nxt;
  logic [CNT_W-1:0] w_last;
  logic             w_wrap;
  logic             w_apply_req;

  // A programmed period of 0 behaves as 1, so the last count is 0 in both cases.
  assign w_last      = (w_period_act == '0) ? '0 : (w_period_act - CNT_W'(1));
  assign w_wrap      = tick_in && (r_cnt == w_last) && (r_state != IDLE);
  assign w_apply_req = (r_state == IDLE) || w_wrap;

  tick_pwm_shadow #(
    .CNT_W     (CNT_W),
    .PERIOD_RST(PERIOD_RST),
    .DUTY_RST  (DUTY_RST)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_period(cfg_period),
    .cfg_duty  (cfg_duty),
    .apply_req (w_apply_req),
    .period_act(w_period_act),
    .duty_act  (w_duty_act),
    .period_nxt(w_period_nxt),
    .duty_nxt  (w_duty_nxt)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_start_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_next = RUN;
          w_cnt_next   = '0;
          w_start_next = 1'b1;
        end
      end
      RUN: begin
        w_state_next = enable ? RUN : STOP;
        if (w_wrap) begin
          w_cnt_next   = '0;
          w_start_next = 1'b1;
        end else if (tick_in) begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        // Draining: finish the period, then park unless run was re-requested.
        if (w_wrap) begin
          w_cnt_next = '0;
          if (enable) begin
            w_state_next = RUN;
            w_start_next = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          if (tick_in) begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
          if (enable) begin
            w_state_next = RUN;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
    w_pwm_next = (w_state_next != IDLE) && (w_cnt_next < w_duty_nxt);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pwm   <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pwm   <= w_pwm_next;
      r_start <= w_start_next;
    end
  end

  assign pwm_out      = r_pwm;
  assign period_start = r_start;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_tick_pwm_gen.sv
// Directed-vector bench: each driven cycle queues its hand-computed outputs,
// and a monitor compares them one clock later.
module tb_tick_pwm_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_in = 1'b0;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_period = 8'd0;
  logic [7:0] cfg_duty = 8'd0;
  logic       cfg_ready;
  logic       pwm_out;
  logic       period_start;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    int         idx;
    logic [3:0] exp;
  } exp_t;

  exp_t sb_q[$];

  tick_pwm_gen dut (
    .clk         (clk),
    .reset       (reset),
    .tick_in     (tick_in),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_duty    (cfg_duty),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Single-character strings stand for a constant column.
  function automatic logic bit_at(input string s, input int i);
    if (s.len() == 1) return (s[0] == "1");
    return (s[i] == "1");
  endfunction

  // Drive one vector per cycle at negedge; queue {pwm, period_start, busy, cfg_ready}.
  task automatic play(input string name, input string rs, input string ts,
                      input string es, input string vs,
                      input logic [7:0] per, input logic [7:0] duty,
                      input string pw, input string ps, input string bs,
                      input string rd);
    exp_t e;
    for (int i = 0; i < ts.len(); i++) begin
      @(negedge clk);
      reset      = bit_at(rs, i);
      tick_in    = bit_at(ts, i);
      enable     = bit_at(es, i);
      cfg_valid  = bit_at(vs, i);
      cfg_period = per;
      cfg_duty   = duty;
      e.name = name;
      e.idx  = i;
      e.exp  = {bit_at(pw, i), bit_at(ps, i), bit_at(bs, i), bit_at(rd, i)};
      sb_q.push_back(e);
    end
  endtask

  task automatic do_reset(input string name);
    play(name, "01", "00", "0", "0", 8'd0, 8'd0, "0", "0", "0", "1");
  endtask

  initial begin : monitor
    exp_t       e;
    logic [3:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {pwm_out, period_start, busy, cfg_ready};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s[%0d]: pwm/ps/busy/rdy got %b required %b", e.name, e.idx, act, e.exp);
        end else begin
          $display("ok   %s[%0d]: pwm/ps/busy/rdy %b", e.name, e.idx, act);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin : stimulus
    // Reset defaults P=3, D=1, tick every third clock.
    do_reset("rst1");
    play("defaults", "1", "0001001001001001001001001001", "1", "0", 8'd0, 8'd0,
         "1110000001110000001110000001", "1000000001000000001000000001", "1", "1");

    // Mid-period load of P=4, D=2 waits for the wrap.
    do_reset("rst2");
    play("cfg_mid", "1", "0101111111", "1", "0010000000", 8'd4, 8'd2,
         "1000110011", "1000100010", "1", "1100111111");

    // Edge duties: D=0, then D>=P, then P=0.
    do_reset("rst3");
    play("duty0", "1", "0001111", "0011111", "1000000", 8'd4, 8'd0,
         "0", "0010001", "0011111", "0111111");
    play("duty5", "1", "11111111", "1", "10000000", 8'd4, 8'd5,
         "00011111", "00010001", "1", "00011111");
    play("per0", "1", "1111101", "1", "1000000", 8'd0, 8'd1,
         "1", "0001101", "1", "0001111");

    // Graceful stop, then re-assert while draining.
    do_reset("rst4");
    play("stop", "1", "000101110100111", "001100001101111", "100000000000000", 8'd3, 8'd2,
         "001110001111011", "001000001000010", "001111001111111", "011111111111111");

    // Accept coinciding with a wrap applies one period later.
    do_reset("rst5");
    play("wrap_acc", "1", "0111111111", "1", "0001000000", 8'd2, 8'd2,
         "1001001111", "1001001010", "1", "1110001111");

    // Reset mid-run discards pending config and restores defaults.
    do_reset("rst6");
    play("rst_run", "1101111", "0110111", "1", "0110000", 8'd5, 8'd4,
         "1001001", "1001001", "1101111", "1011111");

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: queue entries left got %0d required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
